pipe_scheduler: RTL and testbench

PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

---
 rtl/pipe_scheduler.sv | 143 ++++++++++++++
 tb/tb_pipe_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scheduler.sv
// Pipe ring scheduler for a side-scroller: four pipes move left on each frame tick and wrap
// with a fresh LFSR-derived gap. It tracks the pipe facing the bird and counts the pipes passed.
module pipe_scheduler #(
  parameter int unsigned N_PIPES  = 4,
  parameter int unsigned PIPE_W   = 40,
  parameter int unsigned GAP_H    = 120,
  parameter int unsigned SPACING  = 160,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned GAP_INIT = 180
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic        Lose,
  input  logic        Frame_Tick,
  input  logic [9:0]  Bird_X_L,
  output logic [9:0]  X_Edge_Left,
  output logic [9:0]  X_Edge_Right,
  output logic [9:0]  Y_Edge_Top,
  output logic [9:0]  Y_Edge_Bottom,
  output logic [39:0] Pipes_X,
  output logic [39:0] Pipes_Gap,
  output logic [1:0]  Pipe_Index,
  output logic [7:0]  Score,
  output logic        Q_Idle,
  output logic        Q_Run,
  output logic        Q_Hold
);

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StRun  = 3'b010,
    StHold = 3'b100
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  pipe_x_q [4];
  logic [9:0]  pipe_x_d [4];
  logic [9:0]  gap_q [4];
  logic [9:0]  gap_d [4];
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        passed;
  logic [9:0]  gap_new;

  function automatic logic [9:0] init_x(input int unsigned i);
    return 10'(32'd320 + SPACING * i);
  endfunction

  assign X_Edge_Left   = pipe_x_q[idx_q];
  assign X_Edge_Right  = pipe_x_q[idx_q] + 10'(PIPE_W);
  assign Y_Edge_Top    = gap_q[idx_q];
  assign Y_Edge_Bottom = gap_q[idx_q] + 10'(GAP_H);
  assign Pipe_Index    = idx_q;
  assign Score         = score_q;
  assign Q_Idle        = state_q[0];
  assign Q_Run         = state_q[1];
  assign Q_Hold        = state_q[2];

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign Pipes_X[10*g +: 10]   = pipe_x_q[g];
    assign Pipes_Gap[10*g +: 10] = gap_q[g];
  end

  // Gap top spans 60..314 in steps of 2.
  assign gap_new = 10'd60 + {2'b00, lfsr_q[6:0], 1'b0};
  assign passed  = X_Edge_Right < Bird_X_L;

  always_comb begin
    state_d  = state_q;
    pipe_x_d = pipe_x_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    score_d  = score_q;
    // Taps 8,6,5,4; a maximal-length sequence seeded nonzero never reaches zero.
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRun;
          score_d = 8'd0;
        end
      end
      StRun: begin
        if (Lose) begin
          state_d = StHold;
        end else begin
          if (Frame_Tick) begin
            for (int unsigned i = 0; i < 4; i++) begin
              if (pipe_x_q[i] >= 10'(SPEED)) begin
                pipe_x_d[i] = pipe_x_q[i] - 10'(SPEED);
              end else begin
                pipe_x_d[i] = pipe_x_q[i] + 10'(N_PIPES * SPACING - SPEED);
                gap_d[i]    = gap_new;
              end
            end
          end
          if (passed) begin
            idx_d = idx_q + 2'd1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end
        end
      end
      StHold: begin
        if (Ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Any cycle that lands in IDLE re-initialises the ring.
    if (state_d == StIdle) begin
      for (int unsigned i = 0; i < 4; i++) begin
        pipe_x_d[i] = init_x(i);
        gap_d[i]    = 10'(GAP_INIT);
      end
      idx_d = 2'd0;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      for (int unsigned i = 0; i < 4; i++) begin
        pipe_x_q[i] <= init_x(i);
        gap_q[i]    <= 10'(GAP_INIT);
      end
      idx_q   <= 2'd0;
      score_q <= 8'd0;
      lfsr_q  <= 8'hA5;
    end else begin
      state_q  <= state_d;
      pipe_x_q <= pipe_x_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      score_q  <= score_d;
      lfsr_q   <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the pipe ring.
module tb_pipe_scheduler;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0, Ack = 1'b0, Lose = 1'b0, Frame_Tick = 1'b0;
  logic [9:0]  Bird_X_L = 10'd100;
  logic [9:0]  X_Edge_Left, X_Edge_Right, Y_Edge_Top, Y_Edge_Bottom;
  logic [39:0] Pipes_X, Pipes_Gap;
  logic [1:0]  Pipe_Index;
  logic [7:0]  Score;
  logic        Q_Idle, Q_Run, Q_Hold;

  pipe_scheduler dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Lose(Lose),
    .Frame_Tick(Frame_Tick), .Bird_X_L(Bird_X_L),
    .X_Edge_Left(X_Edge_Left), .X_Edge_Right(X_Edge_Right),
    .Y_Edge_Top(Y_Edge_Top), .Y_Edge_Bottom(Y_Edge_Bottom),
    .Pipes_X(Pipes_X), .Pipes_Gap(Pipes_Gap), .Pipe_Index(Pipe_Index), .Score(Score),
    .Q_Idle(Q_Idle), .Q_Run(Q_Run), .Q_Hold(Q_Hold)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 idle, 1 run, 2 hold.
  int m_state, m_idx, m_score, m_lfsr;
  int m_x [4];
  int m_gap [4];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_init_pipes();
    for (int i = 0; i < 4; i++) begin
      m_x[i]   = 320 + 160 * i;
      m_gap[i] = 180;
    end
    m_idx = 0;
  endtask

  task automatic m_reset();
    m_state = 0;
    m_score = 0;
    m_lfsr  = 'hA5;
    m_init_pipes();
  endtask

  task automatic m_step();
    int nxt;
    int fb;
    bit pass;
    nxt = m_state;
    fb  = $countones(m_lfsr & 'hB8) % 2;
    case (m_state)
      0: if (Start) begin nxt = 1; m_score = 0; end
      1: begin
        if (Lose) nxt = 2;
        else begin
          pass = (m_x[m_idx] + 40) < int'(Bird_X_L);
          if (Frame_Tick) begin
            for (int i = 0; i < 4; i++) begin
              if (m_x[i] >= 2) m_x[i] = m_x[i] - 2;
              else begin
                m_x[i]   = m_x[i] + 4 * 160 - 2;
                m_gap[i] = 60 + 2 * (m_lfsr % 128);
              end
            end
          end
          if (pass) begin
            m_idx = (m_idx + 1) % 4;
            if (m_score < 255) m_score++;
          end
        end
      end
      default: if (Ack) nxt = 0;
    endcase
    m_lfsr  = (m_lfsr * 2 + fb) % 256;
    m_state = nxt;
    if (m_state == 0) m_init_pipes();
  endtask

  always @(posedge Clk or posedge reset) begin
    if (reset) m_reset();
    else m_step();
  end

  always @(negedge Clk) begin
    logic [39:0] ex_x, ex_g;
    logic [2:0]  ex_q;
    for (int i = 0; i < 4; i++) begin
      ex_x[10*i +: 10] = 10'(m_x[i]);
      ex_g[10*i +: 10] = 10'(m_gap[i]);
    end
    ex_q = 3'(1 << m_state);
    chk("pipes_x", Pipes_X, ex_x);
    chk("pipes_gap", Pipes_Gap, ex_g);
    chk("pipe_index", Pipe_Index, 40'(m_idx));
    chk("score", Score, 40'(m_score));
    chk("state_flags", {Q_Hold, Q_Run, Q_Idle}, ex_q);
    chk("x_left", X_Edge_Left, 40'(m_x[m_idx]));
    chk("x_right", X_Edge_Right, 40'(m_x[m_idx] + 40));
    chk("y_top", Y_Edge_Top, 40'(m_gap[m_idx]));
    chk("y_bottom", Y_Edge_Bottom, 40'(m_gap[m_idx] + 120));
  end

  task automatic cyc(input bit st, input bit ak, input bit ls, input bit ft);
    Start = st; Ack = ak; Lose = ls; Frame_Tick = ft;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int guard;
    logic [9:0] g0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_pipes_x", Pipes_X, {10'd800, 10'd640, 10'd480, 10'd320});
    chk("rst_score", Score, 40'd0);
    chk("rst_flags", {Q_Hold, Q_Run, Q_Idle}, 40'b001);
    reset = 1'b0;

    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 1);
    chk("ten_ticks_x", Pipes_X, {10'd780, 10'd620, 10'd460, 10'd300});
    chk("ten_ticks_score", Score, 40'd0);
    chk("ten_ticks_run", Q_Run, 40'd1);

    guard = 0;
    while (m_x[0] != 58 && guard < 400) begin cyc(0, 0, 0, 1); guard++; end
    chk("reach_x58", guard < 400, 40'd1);
    chk("x58_no_pass_yet", Score, 40'd0);
    chk("x58_left", X_Edge_Left, 40'd58);
    cyc(0, 0, 0, 0);
    chk("pass_index", Pipe_Index, 40'd1);
    chk("pass_score", Score, 40'd1);
    chk("pass_left", X_Edge_Left, 40'd218);

    guard = 0;
    while (m_x[0] != 0 && guard < 100) begin cyc(0, 0, 0, 1); guard++; end
    chk("reach_x0", guard < 100, 40'd1);
    cyc(0, 0, 0, 1);
    g0 = Pipes_Gap[9:0];
    chk("wrap_x0", Pipes_X[9:0], 40'd638);
    chk("wrap_gap_range", (g0 >= 10'd60) && (g0 <= 10'd314) && !g0[0], 40'd1);
    chk("wrap_x1", Pipes_X[19:10], 40'd158);

    cyc(0, 0, 1, 1);
    chk("lose_hold", {Q_Hold, Q_Run, Q_Idle}, 40'b100);
    chk("lose_frozen", Pipes_X, {10'd478, 10'd318, 10'd158, 10'd638});
    cyc(0, 1, 0, 0);
    chk("ack_idle", {Q_Hold, Q_Run, Q_Idle}, 40'b001);
    chk("ack_reinit", Pipes_X, {10'd800, 10'd640, 10'd480, 10'd320});
    chk("ack_score_kept", Score, 40'd1);
    cyc(1, 0, 0, 0);
    chk("restart_score", Score, 40'd0);

    Bird_X_L = 10'd1000;
    repeat (299) cyc(0, 0, 0, 0);
    chk("sat_score", Score, 40'd255);
    chk("sat_index3", Pipe_Index, 40'd3);
    cyc(0, 0, 0, 0);
    chk("sat_score_hold", Score, 40'd255);
    chk("sat_index_wrap", Pipe_Index, 40'd0);

    Bird_X_L = 10'd100;
    repeat (5) cyc(0, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_flags", {Q_Hold, Q_Run, Q_Idle}, 40'b001);
    chk("async_rst_score", Score, 40'd0);
    chk("async_rst_x", Pipes_X, {10'd800, 10'd640, 10'd480, 10'd320});
    chk("async_rst_index", Pipe_Index, 40'd0);
    reset = 1'b0;
    @(posedge Clk);
    #1;

    for (int n = 0; n < 4000; n++) begin
      Bird_X_L = 10'($urandom_range(0, 700));
      cyc($urandom % 4 == 0, $urandom % 8 == 0, $urandom % 300 == 0, $urandom % 2 == 1);
      if ($urandom % 700 == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    @(posedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
